// File: rtl/alu_control_regfile.sv
// Single-cycle MIPS-style execute core: decode, 32x32 register file, immediate extend, operand/dest muxes and ALU.
// Outputs are combinational in the same cycle as instr; register writes land on the rising edge (no backpressure).
module alu_control_regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] wb_data,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic        mem_wr,
   output logic        mem_to_reg,
   output logic        branch,
   output logic        jump,
   output logic        zero
);

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctr_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [5:0]  w_opcode;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [5:0]  w_funct;
   logic [15:0] w_imm16;

   assign w_opcode = instr[31:26];
   assign w_rs     = instr[25:21];
   assign w_rt     = instr[20:16];
   assign w_rd     = instr[15:11];
   assign w_funct  = instr[5:0];
   assign w_imm16  = instr[15:0];

   logic     w_reg_dst;
   logic     w_reg_wr;
   logic     w_alu_src;
   logic     w_ext_op;
   logic     w_mem_wr;
   logic     w_mem_to_reg;
   logic     w_branch;
   logic     w_jump;
   alu_ctr_e w_alu_ctr;

   always_comb begin
      w_reg_dst    = 1'b0;
      w_reg_wr     = 1'b0;
      w_alu_src    = 1'b0;
      w_ext_op     = 1'b0;
      w_mem_wr     = 1'b0;
      w_mem_to_reg = 1'b0;
      w_branch     = 1'b0;
      w_jump       = 1'b0;
      w_alu_ctr    = ALU_ADD;
      case (w_opcode)
         OP_RTYPE: begin
            w_reg_dst = 1'b1;
            w_reg_wr  = 1'b1;
            case (w_funct)
               6'b100000: w_alu_ctr = ALU_ADD;
               6'b100010: w_alu_ctr = ALU_SUB;
               6'b100100: w_alu_ctr = ALU_AND;
               6'b100101: w_alu_ctr = ALU_OR;
               6'b100110: w_alu_ctr = ALU_XOR;
               6'b000000: w_alu_ctr = ALU_SLL;
               6'b000010: w_alu_ctr = ALU_SRL;
               6'b101010: w_alu_ctr = ALU_SLT;
               default:   w_reg_wr  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_reg_wr  = 1'b1;
            w_alu_src = 1'b1;
            w_ext_op  = 1'b1;
         end
         OP_ANDI: begin
            w_reg_wr  = 1'b1;
            w_alu_src = 1'b1;
            w_alu_ctr = ALU_AND;
         end
         OP_ORI: begin
            w_reg_wr  = 1'b1;
            w_alu_src = 1'b1;
            w_alu_ctr = ALU_OR;
         end
         OP_XORI: begin
            w_reg_wr  = 1'b1;
            w_alu_src = 1'b1;
            w_alu_ctr = ALU_XOR;
         end
         OP_LW: begin
            w_reg_wr     = 1'b1;
            w_alu_src    = 1'b1;
            w_ext_op     = 1'b1;
            w_mem_to_reg = 1'b1;
         end
         OP_SW: begin
            w_alu_src = 1'b1;
            w_ext_op  = 1'b1;
            w_mem_wr  = 1'b1;
         end
         OP_BEQ: begin
            w_alu_ctr = ALU_SUB;
            w_branch  = 1'b1;
         end
         OP_J: w_jump = 1'b1;
         default: ;
      endcase
   end

   // Register 0 is never written and is forced to read zero on both ports.
   logic [31:0] r_regs [32];
   logic [4:0]  w_rw;
   logic [31:0] w_a;
   logic [31:0] w_b;

   assign w_rw = w_reg_dst ? w_rd : w_rt;
   assign w_a  = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
   assign w_b  = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'd0;
         end
      end else if (w_reg_wr && (w_rw != 5'd0)) begin
         r_regs[w_rw] <= wb_data;
      end
   end

   logic [31:0] w_ext;
   logic [31:0] w_bop;
   logic [31:0] w_alu_res;

   assign w_ext = w_ext_op ? {{16{w_imm16[15]}}, w_imm16} : {16'd0, w_imm16};
   assign w_bop = w_alu_src ? w_ext : w_b;

   always_comb begin
      w_alu_res = 32'd0;
      case (w_alu_ctr)
         ALU_ADD: w_alu_res = w_a + w_bop;
         ALU_SUB: w_alu_res = w_a - w_bop;
         ALU_AND: w_alu_res = w_a & w_bop;
         ALU_OR:  w_alu_res = w_a | w_bop;
         ALU_XOR: w_alu_res = w_a ^ w_bop;
         ALU_SLL: w_alu_res = w_a << w_bop[4:0];
         ALU_SRL: w_alu_res = w_a >> w_bop[4:0];
         ALU_SLT: w_alu_res = {31'd0, ($signed(w_a) < $signed(w_bop))};
         default: w_alu_res = 32'd0;
      endcase
   end

   assign alu_result = w_alu_res;
   assign store_data = w_b;
   assign mem_wr     = w_mem_wr;
   assign mem_to_reg = w_mem_to_reg;
   assign branch     = w_branch;
   assign jump       = w_jump;
   assign zero       = (w_alu_ctr == ALU_SUB) && (w_alu_res == 32'd0);

endmodule

// File: tb/tb_alu_control_regfile.sv
// Bench for alu_control_regfile: directed vector table, reset corner sequence, then random instructions vs. a reference model.
module tb_alu_control_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [31:0] wb_data;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic        mem_wr, mem_to_reg, branch, jump, zero;

   alu_control_regfile dut (
      .clk(clk), .reset(reset), .instr(instr), .wb_data(wb_data),
      .alu_result(alu_result), .store_data(store_data), .mem_wr(mem_wr),
      .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .zero(zero)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference architectural state and the model's view of the current instruction.
   logic [31:0] mregs [32];
   logic [31:0] m_res;
   logic [4:0]  m_flags;   // {mem_wr, mem_to_reg, branch, jump, zero}
   bit          m_valid;
   bit          m_wr;
   logic [4:0]  m_dst;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] wb;
      bit          loop;
      logic [31:0] res;
      bit          chk_res;
      logic [4:0]  flg;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] wb, input bit loop,
                               input logic [31:0] res, input bit chk_res, input logic [4:0] flg);
      vec_t v;
      v.ins = ins; v.wb = wb; v.loop = loop; v.res = res; v.chk_res = chk_res; v.flg = flg;
      return v;
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (instr %h)", name, act, exp, instr);
      end
   endtask

   task automatic model_eval(input logic [31:0] ins);
      logic [31:0] a, b, simm, zimm;
      a    = mregs[ins[25:21]];
      b    = mregs[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'd0, ins[15:0]};
      m_res = 32'd0; m_flags = 5'd0; m_valid = 1; m_wr = 0; m_dst = ins[20:16];
      case (ins[31:26])
         6'd0: begin
            m_wr = 1; m_dst = ins[15:11];
            case (ins[5:0])
               6'h20: m_res = a + b;
               6'h22: begin m_res = a - b; m_flags[0] = (a == b); end
               6'h24: m_res = a & b;
               6'h25: m_res = a | b;
               6'h26: m_res = a ^ b;
               6'h00: m_res = a << b[4:0];
               6'h02: m_res = a >> b[4:0];
               6'h2A: m_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: begin m_wr = 0; m_valid = 0; end
            endcase
         end
         6'h08: begin m_res = a + simm; m_wr = 1; end
         6'h0C: begin m_res = a & zimm; m_wr = 1; end
         6'h0D: begin m_res = a | zimm; m_wr = 1; end
         6'h0E: begin m_res = a ^ zimm; m_wr = 1; end
         6'h23: begin m_res = a + simm; m_wr = 1; m_flags[3] = 1; end
         6'h2B: begin m_res = a + simm; m_flags[4] = 1; end
         6'h04: begin m_res = a - b; m_flags[2] = 1; m_flags[0] = (a == b); end
         6'h02: begin m_res = a + b; m_flags[1] = 1; end
         default: m_res = a + b;
      endcase
   endtask

   task automatic apply(input logic [31:0] ins, input logic [31:0] wb, input logic rst_n);
      @(negedge clk);
      instr = ins; wb_data = wb; reset = rst_n;
      model_eval(ins);
      #1;
   endtask

   task automatic commit();
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      end else if (m_wr && m_dst != 5'd0) begin
         mregs[m_dst] = wb_data;
      end
   endtask

   task automatic check_model(input string tag);
      logic [4:0] mask;
      mask = m_valid ? 5'h1F : 5'h1E;
      if (m_valid) chk({tag, " alu_result"}, alu_result, m_res);
      chk({tag, " flags"}, 32'({mem_wr, mem_to_reg, branch, jump, zero} & mask), 32'(m_flags & mask));
      chk({tag, " store_data"}, store_data, mregs[instr[20:16]]);
   endtask

   initial begin
      logic [31:0] wb, ins;
      logic [4:0]  mask, rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fns [8];
      logic [5:0]  ops [9];
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      reset = 1'b0; instr = 32'd0; wb_data = 32'd0;

      apply(32'd0, 32'd0, 1'b0);
      commit();

      tbl.push_back(mk(enc_r(1, 2, 3, 6'h20), 0, 1, 32'h0, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h08, 0, 1, 16'hFFFB), 0, 1, 32'hFFFFFFFB, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 0, 4, 6'h20), 0, 1, 32'hFFFFFFFB, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h0D, 0, 2, 16'h8000), 0, 1, 32'h00008000, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h08, 0, 1, 16'd12), 0, 1, 32'd12, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h08, 0, 2, 16'd10), 0, 1, 32'd10, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h20), 0, 1, 32'd22, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h22), 0, 1, 32'd2, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h24), 0, 1, 32'd8, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h25), 0, 1, 32'd14, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h26), 0, 1, 32'd6, 1, 5'b00000));
      tbl.push_back(mk(enc_r(2, 1, 6, 6'h2A), 0, 1, 32'd1, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h2A), 0, 1, 32'd0, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h00), 0, 1, 32'd12288, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 6, 6'h02), 0, 1, 32'd0, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 1, 6, 6'h22), 0, 1, 32'd0, 1, 5'b00001));
      tbl.push_back(mk(enc_i(6'h08, 0, 7, 16'hFFFF), 0, 1, 32'hFFFFFFFF, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h0C, 7, 8, 16'h8001), 0, 1, 32'h00008001, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h0E, 7, 8, 16'hFFFF), 0, 1, 32'hFFFF0000, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h08, 0, 8, 16'h8000), 0, 1, 32'hFFFF8000, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h2B, 1, 2, 16'd4), 32'hDEADBEEF, 0, 32'd16, 1, 5'b10000));
      tbl.push_back(mk(enc_r(2, 0, 9, 6'h20), 0, 1, 32'd10, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h23, 1, 5, 16'd4), 32'h12345678, 0, 32'd16, 1, 5'b01000));
      tbl.push_back(mk(enc_r(5, 0, 9, 6'h20), 0, 1, 32'h12345678, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h04, 1, 1, 16'd3), 32'hBAD, 0, 32'd0, 1, 5'b00101));
      tbl.push_back(mk(enc_i(6'h04, 1, 2, 16'd3), 32'hBAD, 0, 32'd2, 1, 5'b00100));
      tbl.push_back(mk({6'b000010, 26'h0210000}, 32'hBAD, 0, 32'd24, 1, 5'b00010));
      tbl.push_back(mk(enc_r(1, 0, 9, 6'h20), 0, 1, 32'd12, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h08, 0, 0, 16'd77), 0, 1, 32'd77, 1, 5'b00000));
      tbl.push_back(mk(enc_r(0, 0, 9, 6'h20), 0, 1, 32'd0, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 1, 6'h3F), 32'hBAD, 0, 32'd0, 0, 5'b00000));
      tbl.push_back(mk(enc_r(1, 0, 9, 6'h20), 0, 1, 32'd12, 1, 5'b00000));
      tbl.push_back(mk(enc_i(6'h3F, 1, 2, 16'h1234), 32'hBAD, 0, 32'd22, 1, 5'b00000));
      tbl.push_back(mk(enc_r(1, 2, 9, 6'h20), 0, 1, 32'd22, 1, 5'b00000));

      foreach (tbl[k]) begin
         wb = tbl[k].loop ? tbl[k].res : tbl[k].wb;
         apply(tbl[k].ins, wb, 1'b1);
         mask = tbl[k].chk_res ? 5'h1F : 5'h1E;
         if (tbl[k].chk_res) chk($sformatf("vec%0d alu_result", k), alu_result, tbl[k].res);
         chk($sformatf("vec%0d flags", k), 32'({mem_wr, mem_to_reg, branch, jump, zero} & mask),
             32'(tbl[k].flg & mask));
         chk($sformatf("vec%0d store_data", k), store_data, mregs[tbl[k].ins[20:16]]);
         commit();
      end

      // Reset low between edges must not disturb reads; at the edge it beats the write.
      apply(enc_i(6'h08, 1, 1, 16'd1), 32'd13, 1'b0);
      chk("rst_between_edges alu_result", alu_result, 32'd13);
      commit();
      apply(enc_r(1, 2, 9, 6'h20), 32'd0, 1'b1);
      chk("rst_priority r1+r2", alu_result, 32'd0);
      commit();
      apply(enc_r(5, 8, 9, 6'h25), 32'd0, 1'b1);
      chk("rst_priority r5|r8", alu_result, 32'd0);
      commit();

      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h2A};
      ops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
      for (int n = 0; n < 400; n++) begin
         rs  = 5'($urandom_range(0, 7));
         rt  = 5'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 7));
         imm = 16'($urandom);
         case ($urandom_range(0, 3))
            0, 1: ins = enc_r(rs, rt, rd, ($urandom_range(0, 15) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)]);
            default: ins = enc_i(ops[$urandom_range(0, 8)], rs, rt, imm);
         endcase
         model_eval(ins);
         wb = ($urandom_range(0, 1) == 1) ? m_res : $urandom;
         apply(ins, wb, ($urandom_range(0, 39) != 0));
         check_model($sformatf("rand%0d", n));
         commit();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_control_regfile.md
Name: alu_control_regfile

Overview:
- Single-cycle MIPS-style execute core with three sub-units: control_logic (instruction decode), regfile (32x32 register file) and alu (32-bit arithmetic/logic).
- Also contains the immediate extender, the destination-register mux and the ALU operand mux.
- Sits between instruction fetch and data memory.
- Data memory and the write-back mux (ALU result vs. memory data) are external; the selected write-back value returns on wb_data.

Parameters:
- none (fixed 32-bit data, 32 registers, 5-bit register addresses)

Ports:
- clk  in  1  clock; all register writes on rising edge
- reset  in  1  synchronous, active-low reset
- instr  in  32  current instruction
- wb_data  in  32  write-back value for the register file (external mux output)
- alu_result  out  32  ALU result; also the data-memory address
- store_data  out  32  regfile port-B value (rt contents); data-memory write data
- mem_wr  out  1  data-memory write enable (MemWr)
- mem_to_reg  out  1  write-back select, 1 = memory data (MemtoReg)
- branch  out  1  instruction is beq
- jump  out  1  instruction is j
- zero  out  1  1 when ALUCtr = 001 (sub) and alu_result = 0

Behaviour:
- Instruction fields:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm16 = [15:0].
- ALUCtr encoding:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 sll: A << Bop[4:0]
  - 110 srl: logical A >> Bop[4:0]
  - 111 slt: signed, result 1 or 0
  - add/sub wrap mod 2^32; no overflow flag.
- R-type (opcode 000000), selected by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 000000 sll, 000010 srl, 101010 slt.
  - RegDst=1, RegWr=1, ALUSrc=0.
  - Unknown funct: RegWr=0.
- I-type:
  - addi 001000: ExtOp=1, add.
  - andi 001100 / ori 001101 / xori 001110: ExtOp=0 (zero-extend), and/or/xor.
  - All four: RegDst=0, RegWr=1, ALUSrc=1.
- lw 100011: ExtOp=1, ALUSrc=1, add, RegWr=1, RegDst=0, MemtoReg=1.
- sw 101011: ExtOp=1, ALUSrc=1, add, MemWr=1, RegWr=0.
- beq 000100: ALUSrc=0, sub, branch=1, RegWr=0.
- j 000010: jump=1; no register or memory write.
- Any other opcode: all enables 0, ALUCtr=000.
- Decode is purely combinational. Every control output is defined (never X) for every instr value.
- Extension:
  - ExtOp=1 gives {16{imm16[15]}, imm16}.
  - ExtOp=0 gives {16'b0, imm16}.
- Operand mux: Bop = ALUSrc ? Extension : store_data.
- Write address: rw = RegDst ? rd : rt.
- Register file reads:
  - Two combinational (asynchronous) read ports: A = reg[rs], B = reg[rt].
  - Register 0 always reads 0.
- Register file write:
  - On rising clk with reset=1 and RegWr=1: reg[rw] <= wb_data.
  - Writes to register 0 are ignored.
  - A read of the register being written returns the old value until the edge (no bypass).
- Reset:
  - On rising clk with reset=0, all 32 registers clear to 0, overriding any write that cycle.
  - Reset asserted mid-program clears state at the next edge; no effect between edges.
- Outputs have no reset of their own: alu_result, zero, mem_wr, mem_to_reg, branch and jump are combinational functions of instr and register contents.
- Latency:
  - ALU and decode results are valid in the same cycle instr is applied.
  - The register update is visible after the next rising edge.

Test Plan:
- Reset then read: hold reset=0 one edge, release, issue add $3,$1,$2 -> alu_result=0; zero=0 (ALUCtr=000).
- Immediate write-back: addi $1,$0,-5 with wb_data looped from alu_result -> alu_result=32'hFFFFFFFB; after edge reg1=FFFFFFFB. Then ori $2,$0,0x8000 -> 32'h00008000.
- R-type ops with reg1=12, reg2=10: add=22, sub=2, and=8, or=14, xor=6, slt($2,$1)=1. sll reg1 by reg2[4:0]=10 -> 12288.
- Load/store decode: sw $2,4($1) -> mem_wr=1, alu_result=reg1+4, store_data=reg2, no register change. lw $5,4($1) -> mem_to_reg=1, reg5 <= wb_data after edge.
- Branch/jump: beq $1,$1 -> branch=1, zero=1; beq $1,$2 (unequal) -> zero=0. j -> jump=1 with no writes. Write with rw=0 -> reg0 stays 0.
- Reset priority: RegWr=1 and reset=0 on the same edge -> all registers 0 afterwards.
